// File: rtl/vx_stream_pkg.sv
// Shared stream helpers used by the response demux.
// Holds the requester-index width helper and the perf counter width.
package vx_stream_pkg;

  localparam int PERF_CNT_W = 32;

  // Index field width: a single requester still gets a 1-bit field.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rsp_buffer.sv
// Two-entry elastic buffer for one demux output.
// not_full is registered, so the upstream ready never depends on ready_out.
// reset is asynchronous and active-low.
module vx_rsp_buffer #(
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [DATAW-1:0] data_in,
  output logic             not_full,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  logic [DATAW-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             wr_en;
  logic             rd_en;

  // A push offered while full is ignored even if a pop drains this cycle.
  assign wr_en     = push && not_full;
  assign valid_out = (count != 2'd0);
  assign rd_en     = valid_out && ready_out;
  assign data_out  = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + 2'd1;
      2'b01:   count_next = count - 2'd1;
      default: count_next = count;
    endcase
  end

  // Storage, pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      not_full <= 1'b1;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      count    <= count_next;
      not_full <= (count_next != 2'd2);
      if (wr_en) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd_en) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

endmodule

// File: rtl/vx_rsp_demux.sv
// Response demultiplexer: steers each tagged response to the requester
// whose index is embedded in the payload at data_in[SEL_LSB +: LOG].
// BUFFERED=0 is a combinational passthrough; BUFFERED=1 puts a 2-entry
// elastic buffer on every output. Out-of-range indices are consumed,
// dropped and latched into the sticky sel_err flag.
// reset is asynchronous and active-low.
// Optional feature macro: VX_RSP_DEMUX_PERF_EN adds the perf_stalls counter.
module vx_rsp_demux
  import vx_stream_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int SEL_LSB  = 0,
  parameter int BUFFERED = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  input  logic [DATAW-1:0]          data_in,
  output logic                      ready_in,
  output logic [NUM_REQS-1:0]       valid_out,
  output logic [NUM_REQS*DATAW-1:0] data_out,
  input  logic [NUM_REQS-1:0]       ready_out,
  output logic                      sel_err
`ifdef VX_RSP_DEMUX_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]     perf_stalls
`endif
);

  localparam int LOG = idx_width(NUM_REQS);

  logic [LOG-1:0]      sel;
  logic [NUM_REQS-1:0] hit;
  logic                in_range;
  logic                ready_sel;

  assign sel = data_in[SEL_LSB +: LOG];

  // One-hot target decode; a single requester takes every beat.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      hit[i] = (NUM_REQS == 1) || (32'(sel) == 32'(i));
    end
  end

  assign in_range = (NUM_REQS == 1) || (32'(sel) < NUM_REQS);
  assign ready_in = !in_range || ready_sel;

  if (BUFFERED == 0) begin : g_pass
    assign ready_sel = |(hit & ready_out);
    assign valid_out = {NUM_REQS{valid_in}} & hit;
    assign data_out  = {NUM_REQS{data_in}};
  end else begin : g_buf
    logic [NUM_REQS-1:0] not_full;
    logic [NUM_REQS-1:0] push;

    // Only the targeted buffer's registered not-full gates the input,
    // so a stalled output never blocks beats bound elsewhere.
    assign ready_sel = |(hit & not_full);
    assign push      = {NUM_REQS{valid_in}} & hit & not_full;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_out
      vx_rsp_buffer #(
        .DATAW (DATAW)
      ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push[i]),
        .data_in   (data_in),
        .not_full  (not_full[i]),
        .valid_out (valid_out[i]),
        .data_out  (data_out[i*DATAW +: DATAW]),
        .ready_out (ready_out[i])
      );
    end
  end

  // Sticky flag for responses that name a non-existent requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_err <= 1'b0;
    end else if (valid_in && !in_range) begin
      sel_err <= 1'b1;
    end
  end

`ifdef VX_RSP_DEMUX_PERF_EN
  // Saturating count of cycles where a response is offered but refused.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stalls <= '0;
    end else if (valid_in && !ready_in && (perf_stalls != {PERF_CNT_W{1'b1}})) begin
      perf_stalls <= perf_stalls + PERF_CNT_W'(1);
    end
  end
`endif

endmodule
